dpa_voq_request_gen: RTL and testbench

//  Upstream feeder for the NxN diagonal propagation arbiter (DPA). Keeps per-input virtual

---
 rtl/dpa_voq_request_gen_pkg.sv | 17 +
 rtl/dpa_voq_request_gen_if.sv | 25 ++
 rtl/dpa_voq_request_gen_counter.sv | 36 +++
 rtl/dpa_voq_request_gen.sv | 123 ++++++++++++
 tb/tb_dpa_voq_request_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpa_voq_request_gen_pkg.sv
// Shared constants, row/matrix types and the one-hot-or-zero helper for the DPA request path.
package dpa_pkg;

   localparam int N     = 4;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int DW    = $clog2(N);

   typedef logic [N-1:0] row_t;
   typedef row_t mat_t [N];

   // True when at most one bit of the row is set.
   function automatic logic onehot0(input row_t x);
      return ((x & (x - row_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/dpa_voq_request_gen_if.sv
// Ingress, arbiter and crossbar-side signals of the VOQ request generator, flattened per port.
interface dpa_voq_request_gen_if;
   import dpa_pkg::*;

   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_dest;
   logic [N-1:0]    in_ready;
   logic [N*N-1:0]  request;
   logic [N*N-1:0]  grant;
   logic [N-1:0]    pri_diag;
   logic [N-1:0]    deq_valid;
   logic [N*DW-1:0] deq_dest;
   logic            err;

   modport master (
      output in_valid, in_dest, grant,
      input  in_ready, request, pri_diag, deq_valid, deq_dest, err
   );

   modport slave (
      input  in_valid, in_dest, grant,
      output in_ready, request, pri_diag, deq_valid, deq_dest, err
   );

endinterface

// File: rtl/dpa_voq_request_gen_counter.sv
// Occupancy counter of a single virtual output queue; inc and dec in the same cycle cancel.
module dpa_voq_counter
   import dpa_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic nonempty_o
);

   logic [CW-1:0] countQ, countD;

   // The caller only raises inc_i when not full and dec_i when non-empty, so no wrap guard is needed.
   always_comb begin
      countD = countQ;
      if (inc_i && !dec_i) begin
         countD = countQ + CW'(1);
      end else if (dec_i && !inc_i) begin
         countD = countQ - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         countQ <= '0;
      end else begin
         countQ <= countD;
      end
   end

   assign full_o     = (countQ == CW'(DEPTH));
   assign nonempty_o = (countQ != '0);

endmodule

// File: rtl/dpa_voq_request_gen.sv
// VOQ request generator feeding the diagonal propagation arbiter.
// Define DPA_ROTATE_ON_GRANT_EN to advance pri_diag only in cycles with a legal grant.
module dpa_voq_request_gen
   import dpa_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   dpa_voq_request_gen_if.slave bus
);

   mat_t incM, fullM, nonemptyM, legalM, grantM, grantT;
   row_t rowOk, colOk, accept, inReady;
   logic anyIllegal, anyLegal, advance;

   logic [N-1:0]    deqValidQ, deqValidD;
   logic [N*DW-1:0] deqDestQ, deqDestD;
   row_t            priQ, priD;
   logic            errQ, errD;

   for (genvar gi = 0; gi < N; gi++) begin : gRow
      for (genvar gj = 0; gj < N; gj++) begin : gCol
         dpa_voq_counter uCnt (
            .clk        (clk),
            .rst        (rst),
            .inc_i      (incM[gi][gj]),
            .dec_i      (legalM[gi][gj]),
            .full_o     (fullM[gi][gj]),
            .nonempty_o (nonemptyM[gi][gj])
         );
      end
   end

   // Arrival acceptance looks only at stored occupancy, never at this cycle's grant.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         inReady[i] = ~fullM[i][bus.in_dest[i*DW +: DW]];
         accept[i]  = bus.in_valid[i] & inReady[i];
         for (int j = 0; j < N; j++) begin
            incM[i][j] = accept[i] && (bus.in_dest[i*DW +: DW] == DW'(j));
         end
      end
   end

   // A grant survives only if its row and column are one-hot-or-zero and its VOQ holds a cell.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            grantM[i][j] = bus.grant[i*N + j];
            grantT[j][i] = bus.grant[i*N + j];
         end
      end
      for (int i = 0; i < N; i++) begin
         rowOk[i] = onehot0(grantM[i]);
         colOk[i] = onehot0(grantT[i]);
      end
      anyIllegal = 1'b0;
      anyLegal   = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            legalM[i][j] = grantM[i][j] & rowOk[i] & colOk[j] & nonemptyM[i][j];
            anyIllegal   = anyIllegal | (grantM[i][j] & ~legalM[i][j]);
            anyLegal     = anyLegal | legalM[i][j];
         end
      end
   end

   always_comb begin
      deqValidD = '0;
      deqDestD  = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (legalM[i][j]) begin
               deqValidD[i]           = 1'b1;
               deqDestD[i*DW +: DW]   = DW'(j);
            end
         end
      end
      errD = errQ | anyIllegal;
   end

`ifdef DPA_ROTATE_ON_GRANT_EN
   assign advance = anyLegal;
`else
   assign advance = 1'b1;
`endif

   always_comb begin
      priD = priQ;
      if (advance) begin
         priD = {priQ[N-2:0], priQ[N-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deqValidQ <= '0;
         deqDestQ  <= '0;
         priQ      <= row_t'(1);
         errQ      <= 1'b0;
      end else begin
         deqValidQ <= deqValidD;
         deqDestQ  <= deqDestD;
         priQ      <= priD;
         errQ      <= errD;
      end
   end

   // Requests come straight from the counters so the arbiter sees no combinational loop.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            bus.request[i*N + j] = nonemptyM[i][j];
         end
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.pri_diag  = priQ;
   assign bus.deq_valid = deqValidQ;
   assign bus.deq_dest  = deqDestQ;
   assign bus.err       = errQ;

endmodule

// File: tb/tb_dpa_voq_request_gen.sv
// Self-checking bench for dpa_voq_request_gen: directed scenarios plus randomized traffic against a queue-count model.
module tb_dpa_voq_request_gen;
   import dpa_pkg::*;

   localparam int NN = N * N;

   logic clk;
   logic rst;

   dpa_voq_request_gen_if bus ();

   dpa_voq_request_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nCompared;
   int nMismatched;

   // Reference model: plain cell counts per (input, output) pair.
   int              cnt [N][N];
   int              priIdx;
   logic            errM;
   logic [N-1:0]    deqVM;
   logic [N*DW-1:0] deqDM;

   function automatic logic [N*DW-1:0] mkDest(input int i, input int d);
      logic [N*DW-1:0] v;
      v = '0;
      v[i*DW +: DW] = DW'(d);
      return v;
   endfunction

   function automatic logic [NN-1:0] expRequest();
      logic [NN-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            r[i*N + j] = (cnt[i][j] != 0);
      return r;
   endfunction

   function automatic logic [N-1:0] expReady(input logic [N*DW-1:0] d);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (cnt[i][int'(d[i*DW +: DW])] < DEPTH);
      return r;
   endfunction

   function automatic logic [N-1:0] expPri();
      return N'(1) << priIdx;
   endfunction

   task automatic modelStep(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                            input logic [NN-1:0] g, input logic r);
      int rowHits [N];
      int colHits [N];
      int delta [N][N];
      bit anyLegal;
      if (r) begin
         for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) cnt[i][j] = 0;
         priIdx = 0; errM = 1'b0; deqVM = '0; deqDM = '0;
         return;
      end
      for (int k = 0; k < N; k++) begin rowHits[k] = 0; colHits[k] = 0; end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            delta[i][j] = 0;
            if (g[i*N + j]) begin rowHits[i]++; colHits[j]++; end
         end
      anyLegal = 0; deqVM = '0; deqDM = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (g[i*N + j]) begin
               if (rowHits[i] == 1 && colHits[j] == 1 && cnt[i][j] > 0) begin
                  delta[i][j] -= 1;
                  deqVM[i] = 1'b1;
                  deqDM[i*DW +: DW] = DW'(j);
                  anyLegal = 1;
               end else begin
                  errM = 1'b1;
               end
            end
      for (int i = 0; i < N; i++) begin
         int dd;
         dd = int'(d[i*DW +: DW]);
         if (v[i] && cnt[i][dd] < DEPTH) delta[i][dd] += 1;
      end
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) cnt[i][j] += delta[i][j];
`ifdef DPA_ROTATE_ON_GRANT_EN
      if (anyLegal) priIdx = (priIdx + 1) % N;
`else
      priIdx = (priIdx + 1) % N;
`endif
   endtask

   task automatic setInputs(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [NN-1:0] g);
      bus.in_valid = v;
      bus.in_dest  = d;
      bus.grant    = g;
      #1;
   endtask

   task automatic clockEdge();
      @(posedge clk);
      modelStep(bus.in_valid, bus.in_dest, bus.grant, rst);
      @(negedge clk);
      bus.in_valid = '0;
      bus.in_dest  = '0;
      bus.grant    = '0;
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      setInputs('0, '0, '0);
      clockEdge();
      clockEdge();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      setInputs(4'b1111, '0, '0);
      clockEdge();
      doReset();
      nCompared++;
      if (bus.request !== '0) begin nMismatched++; $display("[TB] FAIL reset_request got %h want 0", bus.request); end
      nCompared++;
      if (bus.in_ready !== 4'b1111) begin nMismatched++; $display("[TB] FAIL reset_ready got %b want 1111", bus.in_ready); end
      nCompared++;
      if (bus.pri_diag !== 4'b0001) begin nMismatched++; $display("[TB] FAIL reset_pri got %b want 0001", bus.pri_diag); end
      nCompared++;
      if (bus.deq_valid !== '0 || bus.deq_dest !== '0 || bus.err !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_deq_err got v=%b d=%h e=%b want 0 0 0", bus.deq_valid, bus.deq_dest, bus.err);
      end
   endtask

   task automatic test_arrival();
      doReset();
      setInputs(4'b0001, mkDest(0, 2), '0);
      nCompared++;
      if (bus.pri_diag !== 4'b0001) begin nMismatched++; $display("[TB] FAIL arrival_pri got %b want 0001", bus.pri_diag); end
      clockEdge();
      nCompared++;
      if (bus.request !== 16'h0004 || bus.request !== expRequest()) begin
         nMismatched++; $display("[TB] FAIL arrival_request got %h want 0004", bus.request);
      end
   endtask

   task automatic test_fill();
      doReset();
      for (int k = 0; k < DEPTH; k++) begin
         setInputs(4'b0010, mkDest(1, 3), '0);
         nCompared++;
         if (bus.in_ready[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL fill_ready_%0d got %b want 1", k, bus.in_ready[1]); end
         clockEdge();
      end
      setInputs(4'b0010, mkDest(1, 3), '0);
      nCompared++;
      if (bus.in_ready !== 4'b1101) begin nMismatched++; $display("[TB] FAIL fill_full got %b want 1101", bus.in_ready); end
      clockEdge();
      setInputs('0, mkDest(1, 3), '0);
      nCompared++;
      if (bus.in_ready[1] !== 1'b0 || cnt[1][3] != DEPTH) begin
         nMismatched++; $display("[TB] FAIL fill_refused got %b want 0", bus.in_ready[1]);
      end
      setInputs('0, mkDest(1, 0), '0);
      nCompared++;
      if (bus.in_ready[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL fill_other_dest got %b want 1", bus.in_ready[1]); end
      // Drain by one; the queue must immediately accept again.
      setInputs('0, mkDest(1, 3), 16'h0080);
      clockEdge();
      setInputs('0, mkDest(1, 3), '0);
      nCompared++;
      if (bus.in_ready[1] !== 1'b1 || bus.request[7] !== 1'b1) begin
         nMismatched++; $display("[TB] FAIL fill_drain got rdy=%b req=%b want 1 1", bus.in_ready[1], bus.request[7]);
      end
   endtask

   task automatic test_dequeue();
      doReset();
      setInputs(4'b0001, mkDest(0, 2), '0);
      clockEdge();
      setInputs('0, '0, 16'h0004);
      clockEdge();
      nCompared++;
      if (bus.deq_valid !== 4'b0001 || bus.deq_dest[DW-1:0] !== 2'd2) begin
         nMismatched++; $display("[TB] FAIL dequeue_out got v=%b d=%h want 0001 dest0=2", bus.deq_valid, bus.deq_dest);
      end
      nCompared++;
      if (bus.request !== '0) begin nMismatched++; $display("[TB] FAIL dequeue_request got %h want 0", bus.request); end
      clockEdge();
      nCompared++;
      if (bus.deq_valid !== '0) begin nMismatched++; $display("[TB] FAIL dequeue_single got %b want 0", bus.deq_valid); end
   endtask

   task automatic test_back_to_back();
      doReset();
      for (int k = 0; k < 3; k++) begin
         setInputs(4'b0100, mkDest(2, 0), '0);
         clockEdge();
      end
      setInputs(4'b0100, mkDest(2, 0), 16'h0100);
      clockEdge();
      nCompared++;
      if (bus.deq_valid !== 4'b0100 || bus.deq_dest[2*DW +: DW] !== 2'd0 || cnt[2][0] != 3) begin
         nMismatched++; $display("[TB] FAIL b2b_deq got v=%b d=%h want 0100 dest2=0", bus.deq_valid, bus.deq_dest);
      end
      for (int k = 0; k < 3; k++) begin
         nCompared++;
         if (bus.request[8] !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_hold_%0d got %b want 1", k, bus.request[8]); end
         setInputs('0, '0, 16'h0100);
         clockEdge();
      end
      nCompared++;
      if (bus.request[8] !== 1'b0 || bus.err !== 1'b0) begin
         nMismatched++; $display("[TB] FAIL b2b_empty got req=%b err=%b want 0 0", bus.request[8], bus.err);
      end
   endtask

   task automatic test_illegal_grant();
      doReset();
      setInputs(4'b0010, mkDest(1, 0), '0);
      clockEdge();
      setInputs(4'b0010, mkDest(1, 1), '0);
      clockEdge();
      setInputs('0, '0, 16'h0030);
      clockEdge();
      nCompared++;
      if (bus.err !== 1'b1 || bus.deq_valid !== '0) begin
         nMismatched++; $display("[TB] FAIL illegal_row got err=%b v=%b want 1 0", bus.err, bus.deq_valid);
      end
      nCompared++;
      if (bus.request[5:4] !== 2'b11) begin nMismatched++; $display("[TB] FAIL illegal_nodec got %b want 11", bus.request[5:4]); end
      for (int k = 0; k < 3; k++) clockEdge();
      nCompared++;
      if (bus.err !== 1'b1) begin nMismatched++; $display("[TB] FAIL illegal_sticky got %b want 1", bus.err); end
      doReset();
      setInputs('0, '0, 16'h0001);
      clockEdge();
      nCompared++;
      if (bus.err !== 1'b1 || bus.deq_valid !== '0) begin
         nMismatched++; $display("[TB] FAIL illegal_empty got err=%b v=%b want 1 0", bus.err, bus.deq_valid);
      end
      doReset();
      nCompared++;
      if (bus.err !== 1'b0) begin nMismatched++; $display("[TB] FAIL illegal_clear got %b want 0", bus.err); end
   endtask

   task automatic test_rotation();
      logic [N-1:0] seq [5];
`ifdef DPA_ROTATE_ON_GRANT_EN
      seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
      doReset();
      for (int k = 0; k < 5; k++) begin
         nCompared++;
         if (bus.pri_diag !== seq[k]) begin nMismatched++; $display("[TB] FAIL rotation_%0d got %b want %b", k, bus.pri_diag, seq[k]); end
         clockEdge();
      end
   endtask

   function automatic logic [NN-1:0] pickGrant();
      logic [NN-1:0] g;
      logic [N-1:0]  used;
      g = '0;
      used = '0;
      if ($urandom_range(0, 9) == 0) begin
         g = NN'($urandom) & NN'($urandom);
      end else begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               int j0;
               j0 = $urandom_range(0, N - 1);
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (j0 + k) % N;
                  if (cnt[i][j] > 0 && !used[j]) begin
                     g[i*N + j] = 1'b1;
                     used[j] = 1'b1;
                     break;
                  end
               end
            end
         end
      end
      return g;
   endfunction

   task automatic test_random();
      logic [N-1:0]    v;
      logic [N*DW-1:0] d;
      doReset();
      for (int c = 0; c < 400; c++) begin
         if (c % 80 == 79) doReset();
         v = N'($urandom);
         d = (N*DW)'($urandom);
         setInputs(v, d, pickGrant());
         nCompared++;
         if (bus.in_ready !== expReady(d)) begin
            nMismatched++; $display("[TB] FAIL rand_ready c=%0d got %b want %b", c, bus.in_ready, expReady(d));
         end
         clockEdge();
         nCompared++;
         if (bus.request !== expRequest()) begin
            nMismatched++; $display("[TB] FAIL rand_request c=%0d got %h want %h", c, bus.request, expRequest());
         end
         nCompared++;
         if (bus.deq_valid !== deqVM || bus.deq_dest !== deqDM) begin
            nMismatched++; $display("[TB] FAIL rand_deq c=%0d got %b/%h want %b/%h", c, bus.deq_valid, bus.deq_dest, deqVM, deqDM);
         end
         nCompared++;
         if (bus.pri_diag !== expPri() || bus.err !== errM) begin
            nMismatched++; $display("[TB] FAIL rand_pri_err c=%0d got %b/%b want %b/%b", c, bus.pri_diag, bus.err, expPri(), errM);
         end
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst = 1'b1;
      bus.in_valid = '0;
      bus.in_dest  = '0;
      bus.grant    = '0;
      @(negedge clk);
      doReset();
      test_reset();
      test_arrival();
      test_fill();
      test_dequeue();
      test_back_to_back();
      test_illegal_grant();
      test_rotation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
